// File: rtl/sensor_return_packer.sv
// Packs DDR sensor return samples, four 64-bit lanes per 256-bit word (first sample
// in the top lane), and writes each word into the capture FIFO for host readback.
module sensor_return_packer #(
    parameter int NLANE = 4,
    parameter int SW    = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           Num_Samp,
    input  logic [SW-1:0]         din_q1,
    input  logic [SW-1:0]         din_q2,
    input  logic                  din_valid,
    input  logic                  fifo_almost_full,
    output logic [NLANE*64-1:0]   fifo_din,
    output logic                  fifo_wr_en,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [31:0]           samp_count
);

    localparam int LW = $clog2(NLANE);
    localparam int WW = NLANE * 64;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     target_q, target_d;
    logic [31:0]     count_q, count_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [WW-1:0]   asm_q, asm_d;
    logic            ovf_q, ovf_d;
    logic [WW-1:0]   wdata_q, wdata_d;
    logic            wr_q, wr_d;

    logic [63:0]     lane_word;
    logic [WW-1:0]   word_w;
    logic            last_samp;
    logic            commit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            count_q  <= '0;
            lane_q   <= '0;
            asm_q    <= '0;
            ovf_q    <= 1'b0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
            lane_q   <= lane_d;
            asm_q    <= asm_d;
            ovf_q    <= ovf_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
        end
    end

    always_comb begin
        lane_word = {{(32-SW){1'b0}}, din_q2, {(32-SW){1'b0}}, din_q1};
        word_w    = asm_q;
        for (int i = 0; i < NLANE; i++) begin
            if (lane_q == LW'(i)) begin
                word_w[(NLANE-1-i)*64 +: 64] = lane_word;
            end
        end
        last_samp = (count_q + 32'd1) == target_q;
        commit    = (lane_q == LW'(NLANE-1)) || last_samp;
    end

    // A commit pushes the assembled word (or drops it on almost_full) and restarts assembly.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        lane_d   = lane_q;
        asm_d    = asm_q;
        ovf_d    = ovf_q;
        wdata_d  = wdata_q;
        wr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    target_d = Num_Samp;
                    count_d  = '0;
                    lane_d   = '0;
                    asm_d    = '0;
                    ovf_d    = 1'b0;
                    state_d  = (Num_Samp == 32'd0) ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                if (din_valid) begin
                    count_d = count_q + 32'd1;
                    lane_d  = lane_q + LW'(1);
                    asm_d   = word_w;
                    if (commit) begin
                        asm_d  = '0;
                        lane_d = '0;
                        if (!fifo_almost_full) begin
                            wdata_d = word_w;
                            wr_d    = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                        if (last_samp) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fifo_din   = wdata_q;
    assign fifo_wr_en = wr_q;
    assign busy       = (state_q == CAPTURE);
    assign done       = (state_q == DONE);
    assign overflow   = ovf_q;
    assign samp_count = count_q;

endmodule

// File: doc/sensor_return_packer.md
# sensor_return_packer

Receive-side counterpart of the pattern-to-sensor path. The block takes the DDR-captured return stream from the 20-bit sensor bus, one sample per valid cycle, and packs four samples into one 256-bit word. Lanes use the same 64-bit format the transmit FIFO reads out. Each complete word is written into a 256-bit-wide capture FIFO for host readback. It runs on the single capture-side clock and captures a programmed number of samples per run.

## Interface
Parameters:
- `NLANE`, 4, samples per output word (fixed at 4; 4 × 64 = 256).
- `SW`, 20, sensor bus width per DDR edge.

Ports:
- `clk`  in  1  capture clock. All logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting (0) clears all state immediately. Deassertion is synchronous to `clk` upstream.
- `start`  in  1  single-cycle pulse that begins a capture run.
- `Num_Samp`  in  32  samples to capture per run. Latched on `start`.
- `din_q1`  in  20  rising-edge sample (IDDR Q1), already in the `clk` domain.
- `din_q2`  in  20  falling-edge sample (IDDR Q2).
- `din_valid`  in  1  sample qualifier. No backpressure exists.
- `fifo_almost_full`  in  1  almost_full flag of the capture FIFO.
- `fifo_din`  out  256  packed word to the capture FIFO.
- `fifo_wr_en`  out  1  FIFO write strobe, registered.
- `busy`  out  1  high while in CAPTURE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `overflow`  out  1  sticky. Set when a completed word is dropped.
- `samp_count`  out  32  samples observed in the current or last run.

## Operation
- Lane format, one per sample: {12'h000, din_q2[19:0], 12'h000, din_q1[19:0]}. q1 sits in lane bits 19:0 and q2 in bits 51:32, matching the TX 64-bit word.
- Lane order:
  - The first sample of a word goes to `fifo_din[255:192]`, the second to [191:128], the third to [127:64], the fourth to [63:0].
  - This is MSB-first, so a 256→64 asymmetric FIFO reads samples back in arrival order.
- State machine: IDLE, CAPTURE, DONE.
- IDLE:
  - `start`=1 latches `Num_Samp` into a target register and clears `samp_count`, the lane index, the assembly register and `overflow`.
  - If `Num_Samp`=0, the next state is DONE. Otherwise it is CAPTURE.
  - `din_valid` is ignored in IDLE.
- CAPTURE:
  - Each cycle with `din_valid`=1 stores the lane at the current index and increments `samp_count` and the lane index (mod 4).
  - A word commits when the lane index is 3, or when `samp_count`+1 equals the target.
  - On commit with `fifo_almost_full`=0 (sampled that same cycle), the next cycle has `fifo_wr_en`=1 and `fifo_din` = assembled word. Unfilled lanes are zero.
  - On commit with `fifo_almost_full`=1, the word is dropped, `overflow` is set, and `fifo_wr_en` stays 0.
  - On every commit, the assembly register and lane index clear.
  - The final commit moves the state to DONE.
- DONE: lasts one cycle with `done`=1, then the state returns to IDLE.
- `start` is ignored outside IDLE. `din_valid` after the target is reached is ignored.
- Dropped samples still count in `samp_count`, so the count always equals samples observed.

## Timing
- Reset values: `fifo_din`=0, `fifo_wr_en`=0, `busy`=0, `done`=0, `overflow`=0, `samp_count`=0, state IDLE.
- `start` at cycle S: `busy`=1 from S+1.
- Sample accepted at cycle N that completes a word: `fifo_wr_en`=1 at N+1 for exactly 1 cycle, with `fifo_din` valid in that cycle.
- `fifo_din` holds its last written value between writes.
- Final sample at cycle N:
  - `fifo_wr_en`, if not dropped, and `done` are both high at N+1.
  - `busy`=0 from N+1.
  - IDLE at N+2, so a new `start` is accepted at N+2.
- The block sustains back-to-back words: one write every 4 cycles at a continuous `din_valid`.
- `samp_count` updates the cycle after each accepted sample. It wraps mod 2^32, with no special handling.
- Reset asserted mid-run:
  - All outputs return to their reset values asynchronously.
  - Any partial word is discarded and no write is issued.

## Test plan
- Num_Samp=8, continuous valid, q1=i, q2=20'h80000|i (i=0..7) → two writes at the cycles after samples 3 and 7.
  - Word0 [255:192]=64'h00080000_00000000 and [63:0]=64'h00080003_00000003.
  - `done` coincides with the second write. `samp_count`=8, `overflow`=0.
- Num_Samp=6, continuous → second write holds samples 4 and 5 in [255:128], with [127:0]=0. Exactly 2 writes.
- Num_Samp=4, `din_valid` every 3rd cycle → single write 1 cycle after the 4th valid. No writes before it.
- Num_Samp=8, `fifo_almost_full`=1 during the cycle sample 3 is accepted, then 0 → only the second word is written, `overflow`=1, `samp_count`=8, `done` pulses.
- Num_Samp=0 `start` → `done` 1 cycle later, no `fifo_wr_en`. A `start` pulse during CAPTURE of another run is ignored: the count and target are unchanged.
- Reset low after 2 samples of a 4-sample run → all outputs 0, no write. After release, `start` with Num_Samp=4 and 4 new samples → one word with no stale lanes from the aborted run.
